// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the single CPU data bus between two masters.
// m0 (core data port) and m1 (loader/DMA) compete for one transfer per cycle.
// Ties are broken round-robin. A bounded burst lock limits how many back-to-back
// grants the owner gets while the other master waits. Read data is returned
// one cycle after the read to whichever master issued it.

// Protocol invariants for the arbiter, kept apart from the datapath.
module dbus_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic m0_req,
    input logic m1_req,
    input logic m0_gnt,
    input logic m1_gnt,
    input logic bus_wr,
    input logic bus_rd,
    input logic m0_rvalid,
    input logic m1_rvalid
);

    // Only one master may own the bus in any cycle.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
        !(m0_gnt && m1_gnt));

    // A grant is only ever given to a master that is asking for it.
    a_gnt0_req: assert property (@(posedge clk) disable iff (rst)
        m0_gnt |-> m0_req);

    a_gnt1_req: assert property (@(posedge clk) disable iff (rst)
        m1_gnt |-> m1_req);

    // A single granted transfer is either a write or a read, never both.
    a_wr_rd_excl: assert property (@(posedge clk) disable iff (rst)
        !(bus_wr && bus_rd));

    // A returned read belongs to exactly one master.
    a_rvalid_onehot: assert property (@(posedge clk) disable iff (rst)
        !(m0_rvalid && m1_rvalid));

endmodule

module dbus_arbiter #(
    parameter int ADDRWIDTH = 32,
    parameter int MAX_BURST = 4,
    parameter int CNTWIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [ADDRWIDTH-1:0] m0_addr,
    input  logic [31:0]          m0_wdata,
    input  logic [3:0]           m0_wstrb,
    output logic                 m0_gnt,
    output logic                 m0_rvalid,
    output logic [31:0]          m0_rdata,

    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [ADDRWIDTH-1:0] m1_addr,
    input  logic [31:0]          m1_wdata,
    input  logic [3:0]           m1_wstrb,
    output logic                 m1_gnt,
    output logic                 m1_rvalid,
    output logic [31:0]          m1_rdata,

    output logic                 bus_wr,
    output logic [ADDRWIDTH-1:0] bus_waddr,
    output logic [31:0]          bus_wdata,
    output logic [3:0]           bus_wstrb,
    output logic                 bus_rd,
    output logic [ADDRWIDTH-1:0] bus_raddr,
    input  logic [31:0]          bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [CNTWIDTH-1:0] CNT_MAX  = CNTWIDTH'(MAX_BURST);
    localparam logic [CNTWIDTH-1:0] CNT_ONE  = CNTWIDTH'(1);
    localparam logic [CNTWIDTH-1:0] CNT_ZERO = {CNTWIDTH{1'b0}};

    // Arbitration state. last_q is the index of the most recently granted
    // master; resetting it to 1 makes m0 win the first tie.
    state_e                state_q, state_d;
    logic                  last_q,  last_d;
    logic [CNTWIDTH-1:0]   cnt_q,   cnt_d;

    // Outstanding read: valid flag and which master it belongs to.
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_own_q,  rd_own_d;

    logic                  gnt0;
    logic                  gnt1;
    logic                  below_max;
    logic [CNTWIDTH-1:0]   cnt_inc;

    assign below_max = (cnt_q < CNT_MAX);
    assign cnt_inc   = below_max ? (cnt_q + CNT_ONE) : CNT_MAX;

    // Grant decision and next arbitration state from current state and requests.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (m0_req && (!m1_req || last_q)) begin
                    gnt0    = 1'b1;
                    state_d = OWN0;
                    cnt_d   = CNT_ONE;
                    last_d  = 1'b0;
                end else if (m1_req) begin
                    gnt1    = 1'b1;
                    state_d = OWN1;
                    cnt_d   = CNT_ONE;
                    last_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            OWN0: begin
                if (m0_req && (below_max || !m1_req)) begin
                    gnt0    = 1'b1;
                    state_d = OWN0;
                    cnt_d   = cnt_inc;
                    last_d  = 1'b0;
                end else if (m1_req) begin
                    gnt1    = 1'b1;
                    state_d = OWN1;
                    cnt_d   = CNT_ONE;
                    last_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            OWN1: begin
                if (m1_req && (below_max || !m0_req)) begin
                    gnt1    = 1'b1;
                    state_d = OWN1;
                    cnt_d   = cnt_inc;
                    last_d  = 1'b1;
                end else if (m0_req) begin
                    gnt0    = 1'b1;
                    state_d = OWN0;
                    cnt_d   = CNT_ONE;
                    last_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                last_d  = 1'b1;
            end
        endcase
    end

    // No transfer can be accepted while reset is held, so every output is quiet.
    assign m0_gnt = gnt0 & ~rst;
    assign m1_gnt = gnt1 & ~rst;

    // Record a granted read so its data can be routed back next cycle.
    always_comb begin
        rd_pend_d = 1'b0;
        rd_own_d  = rd_own_q;
        if (m0_gnt && !m0_we) begin
            rd_pend_d = 1'b1;
            rd_own_d  = 1'b0;
        end else if (m1_gnt && !m1_we) begin
            rd_pend_d = 1'b1;
            rd_own_d  = 1'b1;
        end else begin
            rd_pend_d = 1'b0;
            rd_own_d  = rd_own_q;
        end
    end

    // Arbitration and read-tracking registers; reset drops any pending read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= CNT_ZERO;
            rd_pend_q <= 1'b0;
            rd_own_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_own_q  <= rd_own_d;
        end
    end

    // Steer the granted master's transfer onto the bus; all fields zero otherwise.
    always_comb begin
        bus_wr    = 1'b0;
        bus_rd    = 1'b0;
        bus_waddr = {ADDRWIDTH{1'b0}};
        bus_wdata = 32'h0000_0000;
        bus_wstrb = 4'h0;
        bus_raddr = {ADDRWIDTH{1'b0}};
        if (m0_gnt) begin
            if (m0_we) begin
                bus_wr    = 1'b1;
                bus_waddr = m0_addr;
                bus_wdata = m0_wdata;
                bus_wstrb = m0_wstrb;
            end else begin
                bus_rd    = 1'b1;
                bus_raddr = m0_addr;
            end
        end else if (m1_gnt) begin
            if (m1_we) begin
                bus_wr    = 1'b1;
                bus_waddr = m1_addr;
                bus_wdata = m1_wdata;
                bus_wstrb = m1_wstrb;
            end else begin
                bus_rd    = 1'b1;
                bus_raddr = m1_addr;
            end
        end else begin
            bus_wr = 1'b0;
            bus_rd = 1'b0;
        end
    end

    // Route last cycle's read data to its owner; the other master sees zeros.
    always_comb begin
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rdata  = 32'h0000_0000;
        m1_rdata  = 32'h0000_0000;
        if (rd_pend_q) begin
            if (rd_own_q) begin
                m1_rvalid = 1'b1;
                m1_rdata  = bus_rdata;
            end else begin
                m0_rvalid = 1'b1;
                m0_rdata  = bus_rdata;
            end
        end else begin
            m0_rvalid = 1'b0;
            m1_rvalid = 1'b0;
        end
    end

    dbus_arbiter_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m1_req    (m1_req),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .m0_rvalid (m0_rvalid),
        .m1_rvalid (m1_rvalid)
    );

endmodule
